hdmipll_lock_supervisor: RTL and testbench



---
 rtl/hdmipll_lock_supervisor_if.sv | 19 +
 rtl/hdmipll_lock_supervisor.sv | 90 +++++++++
 tb/tb_hdmipll_lock_supervisor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hdmipll_lock_supervisor_if.sv
// hdmipll_lock_supervisor_if: PLL lock/status bus; master = supervisor (drives pll_rst, sys_rst, ready, status), slave = PLL/host side (drives pll_locked, clr_status)
interface hdmipll_lock_supervisor_if;
  logic pll_locked;
  logic clr_status;
  logic pll_rst;
  logic sys_rst;
  logic ready;
  logic timeout_err;
  logic [7:0] loss_count;
  logic [7:0] retry_count;
  modport master (
    input pll_locked, clr_status,
    output pll_rst, sys_rst, ready, timeout_err, loss_count, retry_count
  );
  modport slave (
    output pll_locked, clr_status,
    input pll_rst, sys_rst, ready, timeout_err, loss_count, retry_count
  );
endinterface

// File: rtl/hdmipll_lock_supervisor.sv
// hdmipll_lock_supervisor: PLL reset sequencer and lock qualifier; ports refclk, rst, bus (pll_locked/clr_status in; pll_rst/sys_rst/ready/timeout_err/loss_count/retry_count out); HDMIPLL_LOCK_GLITCH_FILTER_EN adds a RUN-state dropout filter
module hdmipll_lock_supervisor #(
  parameter int RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4000000,
  parameter int STABLE_CYCLES = 4096,
  parameter int GLITCH_CYCLES = 4
) (
  input logic refclk,
  input logic rst,
  hdmipll_lock_supervisor_if.master bus
);
  localparam int M0 = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int M1 = STABLE_CYCLES > GLITCH_CYCLES ? STABLE_CYCLES : GLITCH_CYCLES;
  localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);
  localparam logic [1:0] PLL_RESET = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABLE = 2'd2;
  localparam logic [1:0] RUN = 2'd3;
  logic [1:0] state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic s1, locked_s, loss, tmo;
`ifdef HDMIPLL_LOCK_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic [GW-1:0] gcnt;
  always_ff @(posedge refclk) begin
    if (rst || state != RUN || locked_s) gcnt <= '0;
    else if (gcnt != GW'(GLITCH_CYCLES - 1)) gcnt <= gcnt + 1'b1;
  end
  assign loss = state == RUN && !locked_s && gcnt == GW'(GLITCH_CYCLES - 1);
`else
  assign loss = state == RUN && !locked_s;
`endif
  always_comb begin
    nxt = state;
    cnt_n = cnt + 1'b1;
    tmo = 1'b0;
    case (state)
      PLL_RESET: if (cnt == CW'(RST_CYCLES)) begin
        nxt = WAIT_LOCK;
        cnt_n = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        nxt = STABLE;
        cnt_n = '0;
      end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
        nxt = PLL_RESET;
        cnt_n = CW'(1);
        tmo = 1'b1;
      end
      STABLE: if (!locked_s) begin
        nxt = WAIT_LOCK;
        cnt_n = '0;
      end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
        nxt = RUN;
        cnt_n = '0;
      end
      default: begin
        nxt = loss ? PLL_RESET : RUN;
        cnt_n = loss ? CW'(1) : '0;
      end
    endcase
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      s1 <= 1'b0;
      locked_s <= 1'b0;
      state <= PLL_RESET;
      cnt <= '0;
      bus.pll_rst <= 1'b1;
      bus.sys_rst <= 1'b1;
      bus.ready <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.loss_count <= 8'd0;
      bus.retry_count <= 8'd0;
    end else begin
      s1 <= bus.pll_locked;
      locked_s <= s1;
      state <= nxt;
      cnt <= cnt_n;
      bus.pll_rst <= nxt == PLL_RESET;
      bus.sys_rst <= nxt != RUN;
      bus.ready <= nxt == RUN;
      bus.timeout_err <= tmo | (bus.timeout_err & ~bus.clr_status);
      bus.retry_count <= tmo ? (bus.clr_status ? 8'd1 : bus.retry_count + {7'd0, bus.retry_count != 8'hff})
                             : (bus.clr_status ? 8'd0 : bus.retry_count);
      bus.loss_count <= loss ? (bus.clr_status ? 8'd1 : bus.loss_count + {7'd0, bus.loss_count != 8'hff})
                             : (bus.clr_status ? 8'd0 : bus.loss_count);
    end
  end
endmodule

// File: tb/tb_hdmipll_lock_supervisor.sv
// tb_hdmipll_lock_supervisor: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_hdmipll_lock_supervisor;
`ifdef HDMIPLL_LOCK_GLITCH_FILTER_EN
  localparam int PW = 3;
  localparam int LD = 4;
  localparam int PS = 28;
`else
  localparam int PW = 1;
  localparam int LD = 2;
  localparam int PS = 20;
`endif
  localparam int P = LD + 14;
  typedef struct {
    int at;
    string nm;
    logic [19:0] v;
  } vec_t;
  logic refclk;
  logic rst;
  int edges = 0;
  int vectors = 0;
  int miscompares = 0;
  vec_t q[$];
  vec_t ex;
  logic [19:0] act;
  hdmipll_lock_supervisor_if bus();
  hdmipll_lock_supervisor #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(32),
    .STABLE_CYCLES(8),
    .GLITCH_CYCLES(3)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) edges++;
  always @(negedge refclk) begin
    while (q.size() != 0 && q[0].at <= edges - 1) begin
      ex = q.pop_front();
      act = {bus.pll_rst, bus.sys_rst, bus.ready, bus.timeout_err, bus.loss_count, bus.retry_count};
      vectors++;
      if (act !== ex.v) begin
        miscompares++;
        $display("FAIL %s @edge %0d: got pr=%b sr=%b rdy=%b te=%b lc=%0d rc=%0d, want pr=%b sr=%b rdy=%b te=%b lc=%0d rc=%0d",
                 ex.nm, ex.at, act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                 ex.v[19], ex.v[18], ex.v[17], ex.v[16], ex.v[15:8], ex.v[7:0]);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end
  task automatic exp_at(input int at, input string nm, input logic pr, input logic sr, input logic rdy,
                        input logic te, input logic [7:0] lc, input logic [7:0] rc);
    vec_t e;
    e.at = at;
    e.nm = nm;
    e.v = {pr, sr, rdy, te, lc, rc};
    q.push_back(e);
  endtask
  task automatic to_edge(input int abs);
    while (edges - 1 < abs) @(negedge refclk);
  endtask
  task automatic pulse(input int p, input int w);
    to_edge(p - 1);
    bus.pll_locked = 1'b0;
    to_edge(p + w - 1);
    bus.pll_locked = 1'b1;
  endtask
  initial begin
    int base, p0, pk, lk, ll, qq, lq, r;
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    bus.clr_status = 1'b0;
    to_edge(1);
    exp_at(2, "reset", 1, 1, 0, 0, 0, 0);
    to_edge(3);
    rst = 1'b0;
    base = edges;
    exp_at(base + 3, "clean_prst", 1, 1, 0, 0, 0, 0);
    exp_at(base + 4, "clean_wait", 0, 1, 0, 0, 0, 0);
    exp_at(base + 12, "clean_prerun", 0, 1, 0, 0, 0, 0);
    exp_at(base + 13, "clean_run", 0, 0, 1, 0, 0, 0);
    exp_at(base + 15, "rst_from_run", 1, 1, 0, 0, 0, 0);
    to_edge(base + 14);
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    to_edge(base + 16);
    rst = 1'b0;
    base = edges;
    exp_at(base + 35, "to_pre", 0, 1, 0, 0, 0, 0);
    exp_at(base + 36, "to_first", 1, 1, 0, 1, 0, 1);
    exp_at(base + 39, "to_prst", 1, 1, 0, 1, 0, 1);
    exp_at(base + 40, "to_rearm", 0, 1, 0, 1, 0, 1);
    exp_at(base + 71, "to_pre2", 0, 1, 0, 1, 0, 1);
    exp_at(base + 72, "to_second", 1, 1, 0, 1, 0, 2);
    exp_at(base + 74, "clr_alone", 1, 1, 0, 0, 0, 0);
    to_edge(base + 73);
    bus.clr_status = 1'b1;
    to_edge(base + 74);
    bus.clr_status = 1'b0;
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    to_edge(base + 76);
    rst = 1'b0;
    base = edges;
    exp_at(base + 13, "bounce_norun", 0, 1, 0, 0, 0, 0);
    exp_at(base + 17, "bounce_prerun", 0, 1, 0, 0, 0, 0);
    exp_at(base + 18, "bounce_run", 0, 0, 1, 0, 0, 0);
`ifdef HDMIPLL_LOCK_GLITCH_FILTER_EN
    exp_at(base + 26, "glitch_ignored", 0, 0, 1, 0, 0, 0);
`endif
    exp_at(base + PS + LD - 1, "loss_pre", 0, 0, 1, 0, 0, 0);
    exp_at(base + PS + LD, "loss_hit", 1, 1, 0, 0, 1, 0);
    exp_at(base + PS + LD + 3, "loss_prst", 1, 1, 0, 0, 1, 0);
    exp_at(base + PS + LD + 4, "loss_wait", 0, 1, 0, 0, 1, 0);
    exp_at(base + PS + LD + 12, "loss_prerun", 0, 1, 0, 0, 1, 0);
    exp_at(base + PS + LD + 13, "relock", 0, 0, 1, 0, 1, 0);
    pulse(base + 7, 1);
`ifdef HDMIPLL_LOCK_GLITCH_FILTER_EN
    pulse(base + 20, 2);
`endif
    pulse(base + PS, PW);
    p0 = base + PS + LD + 14;
    lk = p0;
    for (int k = 0; k < 260; k++) begin
      pk = p0 + k * P;
      lk = pk + LD;
      if (k == 0 || k == 252 || k == 253 || k == 258)
        exp_at(lk, $sformatf("sat_%0d", k), 1, 1, 0, 0, 8'((k + 2 > 255) ? 255 : k + 2), 0);
      if (k == 259) exp_at(lk, "clr_vs_loss", 1, 1, 0, 0, 1, 0);
      pulse(pk, PW);
      if (k == 259) begin
        to_edge(lk - 1);
        bus.clr_status = 1'b1;
        to_edge(lk);
        bus.clr_status = 1'b0;
      end
    end
    ll = lk;
    exp_at(ll + 14, "clr_pre", 0, 0, 1, 0, 1, 0);
    exp_at(ll + 15, "clr_in_run", 0, 0, 1, 0, 0, 0);
    to_edge(ll + 14);
    bus.clr_status = 1'b1;
    to_edge(ll + 15);
    bus.clr_status = 1'b0;
    qq = ll + 17;
    lq = qq + LD;
    exp_at(lq, "loss_again", 1, 1, 0, 0, 1, 0);
    exp_at(lq + 13, "run_again", 0, 0, 1, 0, 1, 0);
    pulse(qq, PW);
    r = lq + 15;
    exp_at(r - 1, "pre_rst", 0, 0, 1, 0, 1, 0);
    exp_at(r, "rst_in_run", 1, 1, 0, 0, 0, 0);
    to_edge(r - 1);
    rst = 1'b1;
    to_edge(r);
    rst = 1'b0;
    base = edges;
    exp_at(base + 3, "rerun_prst", 1, 1, 0, 0, 0, 0);
    exp_at(base + 4, "rerun_wait", 0, 1, 0, 0, 0, 0);
    exp_at(base + 12, "rerun_prerun", 0, 1, 0, 0, 0, 0);
    exp_at(base + 13, "rerun_run", 0, 0, 1, 0, 0, 0);
    to_edge(base + 16);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending: %0d expectations never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
